// File: rtl/topk_select_pipe.sv
// Streaming top-K selector: each of K pipeline stages extracts the current extreme
// unmasked element (max or min per vector), records value and index, and masks it.
module topk_select_pipe #(
   parameter  int M  = 8,
   parameter  int N  = 8,
   parameter  int K  = 4,
   localparam int IW = $clog2(M)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_flush,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [M*N-1:0]  i_data,
   input  logic            i_mode,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [K*N-1:0]  o_val,
   output logic [K*IW-1:0] o_idx
);

   logic            valid_q [K];
   logic            valid_d [K];
   logic            mode_q  [K];
   logic            mode_d  [K];
   logic [M*N-1:0]  data_q  [K];
   logic [M*N-1:0]  data_d  [K];
   logic [M-1:0]    mask_q  [K];
   logic [M-1:0]    mask_d  [K];
   logic [K*N-1:0]  val_q   [K];
   logic [K*N-1:0]  val_d   [K];
   logic [K*IW-1:0] idx_q   [K];
   logic [K*IW-1:0] idx_d   [K];

   logic            src_valid [K];
   logic            src_mode  [K];
   logic [M*N-1:0]  src_data  [K];
   logic [M-1:0]    src_mask  [K];
   logic [K*N-1:0]  src_val   [K];
   logic [K*IW-1:0] src_idx   [K];

   logic [IW-1:0]   win_idx [K];
   logic [N-1:0]    win_val [K];

   logic            en;

   // Ascending scan with strict compare, so on equal values the lowest index is kept.
   function automatic logic [IW-1:0] pick(input logic [M*N-1:0] d,
                                          input logic [M-1:0]   msk,
                                          input logic           mode);
      logic          found;
      logic [N-1:0]  best;
      logic [IW-1:0] bi;
      found = 1'b0;
      best  = '0;
      bi    = '0;
      for (int j = 0; j < M; j++) begin
         if (!msk[j]) begin
            if (!found || (mode ? (d[j*N +: N] < best) : (d[j*N +: N] > best))) begin
               found = 1'b1;
               best  = d[j*N +: N];
               bi    = IW'(j);
            end
         end
      end
      return bi;
   endfunction

   // The whole pipeline moves as one unit; only the output stage can stall it.
   assign en      = !valid_q[K-1] || i_ready;
   assign o_ready = en;

   always_comb begin
      src_valid[0] = i_valid;
      src_mode[0]  = i_mode;
      src_data[0]  = i_data;
      src_mask[0]  = '0;
      src_val[0]   = '0;
      src_idx[0]   = '0;
      for (int s = 1; s < K; s++) begin
         src_valid[s] = valid_q[s-1];
         src_mode[s]  = mode_q[s-1];
         src_data[s]  = data_q[s-1];
         src_mask[s]  = mask_q[s-1];
         src_val[s]   = val_q[s-1];
         src_idx[s]   = idx_q[s-1];
      end
   end

   always_comb begin
      for (int s = 0; s < K; s++) begin
         win_idx[s] = pick(src_data[s], src_mask[s], src_mode[s]);
         win_val[s] = src_data[s][win_idx[s]*N +: N];
      end
   end

   always_comb begin
      for (int s = 0; s < K; s++) begin
         valid_d[s] = valid_q[s];
         mode_d[s]  = mode_q[s];
         data_d[s]  = data_q[s];
         mask_d[s]  = mask_q[s];
         val_d[s]   = val_q[s];
         idx_d[s]   = idx_q[s];
         if (en) begin
            valid_d[s]                = src_valid[s];
            mode_d[s]                 = src_mode[s];
            data_d[s]                 = src_data[s];
            mask_d[s]                 = src_mask[s] | ({{(M-1){1'b0}}, 1'b1} << win_idx[s]);
            val_d[s]                  = src_val[s];
            val_d[s][s*N +: N]        = win_val[s];
            idx_d[s]                  = src_idx[s];
            idx_d[s][s*IW +: IW]      = win_idx[s];
         end
         // Flush wins over advance; data may keep stale contents behind cleared valids.
         if (i_flush) valid_d[s] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < K; s++) begin
            valid_q[s] <= 1'b0;
            mode_q[s]  <= 1'b0;
            data_q[s]  <= '0;
            mask_q[s]  <= '0;
            val_q[s]   <= '0;
            idx_q[s]   <= '0;
         end
      end else begin
         for (int s = 0; s < K; s++) begin
            valid_q[s] <= valid_d[s];
            mode_q[s]  <= mode_d[s];
            data_q[s]  <= data_d[s];
            mask_q[s]  <= mask_d[s];
            val_q[s]   <= val_d[s];
            idx_q[s]   <= idx_d[s];
         end
      end
   end

   assign o_valid = valid_q[K-1];
   assign o_val   = val_q[K-1];
   assign o_idx   = idx_q[K-1];

endmodule
